// File: rtl/simon_ctrl_if.sv
// Host-side bundle of simon_ctrl: key load, plaintext request and ciphertext response.
// The controller takes the slave view; the host (or a bench) takes the master view.
interface simon_ctrl_if;
  logic [255:0] key_in;
  logic         key_load;
  logic         key_ready;
  logic         key_valid;
  logic         err;
  logic [127:0] pt;
  logic         pt_valid;
  logic         pt_ready;
  logic [127:0] ct;
  logic         ct_valid;
  logic         ct_ready;

  modport master (
    output key_in, key_load, pt, pt_valid, ct_ready,
    input  key_ready, key_valid, err, pt_ready, ct, ct_valid
  );

  modport slave (
    input  key_in, key_load, pt, pt_valid, ct_ready,
    output key_ready, key_valid, err, pt_ready, ct, ct_valid
  );
endinterface

// File: rtl/simon_ctrl.sv
// Simon128/256 sequencer: restarts the external key-schedule block, captures its round keys
// into a local store, then encrypts one 128-bit block at a time at one round per cycle.
module simon_ctrl #(
  parameter int unsigned ROUNDS     = 72,
  parameter int unsigned KS_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          res_n,
  simon_ctrl_if.slave   host,
  output logic          ks_res_n,
  output logic [255:0]  ks_key,
  output logic          ks_start,
  input  logic          ks_wr_en,
  input  logic [6:0]    ks_rnd,
  input  logic [63:0]   ks_key_sched,
  input  logic          ks_done
);

  localparam int unsigned TcntW = $clog2(KS_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StKrst, StKstart, StKgen, StReady, StEnc, StOut, StErr
  } state_e;

  state_e             state_q, state_d;
  logic               key_valid_q, key_valid_d;
  logic               err_q, err_d;
  logic [255:0]       ks_key_q, ks_key_d;
  logic [127:0]       ct_q, ct_d;
  logic [63:0]        x_q, x_d, y_q, y_d;
  logic [6:0]         rcnt_q, rcnt_d;
  logic [6:0]         wcnt_q, wcnt_d;
  logic [TcntW-1:0]   tcnt_q, tcnt_d;
  logic [63:0]        store [ROUNDS];

  logic               key_ready;
  logic               key_accept;
  logic               store_we;
  logic [63:0]        fx;
  logic [63:0]        x_new;

  assign key_ready  = (state_q == StIdle) || (state_q == StReady) || (state_q == StErr);
  assign key_accept = host.key_load && key_ready;

  // f(x) = (rotl1 & rotl8) ^ rotl2
  assign fx    = ({x_q[62:0], x_q[63]} & {x_q[55:0], x_q[63:56]}) ^ {x_q[61:0], x_q[63:62]};
  assign x_new = y_q ^ fx ^ store[rcnt_q];

  // Out-of-range indices are dropped here but still counted in wcnt, forcing ERR.
  assign store_we = (state_q == StKgen) && ks_wr_en && (ks_rnd < 7'(ROUNDS));

  always_comb begin
    state_d     = state_q;
    key_valid_d = key_valid_q;
    err_d       = err_q;
    ks_key_d    = ks_key_q;
    ct_d        = ct_q;
    x_d         = x_q;
    y_d         = y_q;
    rcnt_d      = rcnt_q;
    wcnt_d      = wcnt_q;
    tcnt_d      = tcnt_q;

    if (key_accept) begin
      state_d     = StKrst;
      ks_key_d    = host.key_in;
      key_valid_d = 1'b0;
      err_d       = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StKrst: state_d = StKstart;
        StKstart: begin
          state_d = StKgen;
          wcnt_d  = '0;
          tcnt_d  = '0;
        end
        StKgen: begin
          if (ks_wr_en) wcnt_d = wcnt_q + 7'd1;
          if (ks_done) begin
            if (wcnt_q == 7'(ROUNDS)) begin
              state_d     = StReady;
              key_valid_d = 1'b1;
            end else begin
              state_d     = StErr;
              err_d       = 1'b1;
              key_valid_d = 1'b0;
            end
          end else if (tcnt_q == TcntW'(KS_TIMEOUT - 1)) begin
            state_d     = StErr;
            err_d       = 1'b1;
            key_valid_d = 1'b0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        StReady: begin
          if (host.pt_valid) begin
            x_d     = host.pt[127:64];
            y_d     = host.pt[63:0];
            rcnt_d  = '0;
            state_d = StEnc;
          end
        end
        StEnc: begin
          x_d    = x_new;
          y_d    = x_q;
          rcnt_d = rcnt_q + 7'd1;
          if (rcnt_q == 7'(ROUNDS - 1)) begin
            state_d = StOut;
            ct_d    = {x_new, x_q};
          end
        end
        StOut:   if (host.ct_ready) state_d = StReady;
        StErr:   ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q     <= StIdle;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      ks_key_q    <= '0;
      ct_q        <= '0;
      x_q         <= '0;
      y_q         <= '0;
      rcnt_q      <= '0;
      wcnt_q      <= '0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
      ks_key_q    <= ks_key_d;
      ct_q        <= ct_d;
      x_q         <= x_d;
      y_q         <= y_d;
      rcnt_q      <= rcnt_d;
      wcnt_q      <= wcnt_d;
      tcnt_q      <= tcnt_d;
    end
  end

  // Key store survives reset; key_valid gates its use.
  always_ff @(posedge clk) begin
    if (store_we) store[ks_rnd] <= ks_key_sched;
  end

  assign host.key_ready = key_ready;
  assign host.key_valid = key_valid_q;
  assign host.err       = err_q;
  assign host.pt_ready  = (state_q == StReady) && !host.key_load;
  assign host.ct        = ct_q;
  assign host.ct_valid  = (state_q == StOut);

  assign ks_res_n = res_n && (state_q != StKrst);
  assign ks_key   = ks_key_q;
  assign ks_start = (state_q == StKstart);

endmodule

// File: tb/tb_simon_ctrl.sv
// Bench for simon_ctrl: behavioural Simon128/256 model, a key-schedule generator model and a
// ciphertext scoreboard fed at plaintext acceptance and drained by an output monitor.
module tb_simon_ctrl;
  localparam int unsigned KS_TIMEOUT = 255;
  localparam logic [255:0] KAT_KEY =
    256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] KAT_PT = 128'h74206e69206d6f6f_6d69732061207369;
  localparam logic [127:0] KAT_CT = 128'h8d2b5579afc8a3a0_3bf72a87efe7b868;

  typedef logic [71:0][63:0] rk_t;

  logic clk = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;

  simon_ctrl_if hif ();
  logic         ks_res_n, ks_start;
  logic [255:0] ks_key;
  logic         ks_wr_en = 1'b0;
  logic [6:0]   ks_rnd = '0;
  logic [63:0]  ks_key_sched = '0;
  logic         ks_done = 1'b0;

  simon_ctrl #(.ROUNDS(72), .KS_TIMEOUT(KS_TIMEOUT)) dut (
    .clk(clk), .res_n(res_n), .host(hif),
    .ks_res_n(ks_res_n), .ks_key(ks_key), .ks_start(ks_start), .ks_wr_en(ks_wr_en),
    .ks_rnd(ks_rnd), .ks_key_sched(ks_key_sched), .ks_done(ks_done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] v, input int n);
    return (v << n) | (v >> (64 - n));
  endfunction

  function automatic rk_t expand(input logic [255:0] k);
    rk_t r;
    logic [63:0] z = 64'h3DC94C3A046D678B;
    logic [63:0] t;
    for (int i = 0; i < 4; i++) r[i] = k[i*64 +: 64];
    for (int i = 0; i < 68; i++) begin
      t = rotl(r[i+3], 61) ^ r[i+1];
      t = t ^ rotl(t, 63);
      r[i+4] = ~r[i] ^ t ^ {63'b0, z[i % 62]} ^ 64'd3;
    end
    return r;
  endfunction

  function automatic logic [127:0] encrypt(input rk_t rk, input logic [127:0] p);
    logic [63:0] x = p[127:64];
    logic [63:0] y = p[63:0];
    logic [63:0] t;
    for (int i = 0; i < 72; i++) begin
      t = x;
      x = y ^ ((rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2)) ^ rk[i];
      y = t;
    end
    return {x, y};
  endfunction

  // Key-schedule generator model: reloads on ks_res_n low, writes after ks_start.
  int  kg_nwrites = 72;
  bit  kg_hang = 1'b0;
  bit  kg_go = 1'b0;
  int  kg_idx = 0;
  rk_t kg_rk;
  initial forever begin
    @(posedge clk); #1;
    if (!ks_res_n) begin
      kg_rk = expand(ks_key);
      kg_go = 1'b0; kg_idx = 0; ks_wr_en = 1'b0; ks_done = 1'b0;
    end else begin
      if (kg_go) begin
        if (kg_idx < kg_nwrites) begin
          ks_wr_en     = 1'b1;
          ks_rnd       = 7'(kg_idx);
          ks_key_sched = (kg_idx < 72) ? kg_rk[kg_idx] : 64'hdead_beef_dead_beef;
          kg_idx++;
        end else begin
          ks_wr_en = 1'b0;
          ks_done  = !kg_hang;
        end
      end
      if (ks_start) kg_go = 1'b1;
    end
  end

  // Scoreboard and output monitor
  logic [127:0] exp_q[$];
  int  t_acc = 0;
  bit  lat_pending = 1'b0;
  bit  ctv_prev = 1'b0;
  bit  stall_rand = 1'b0;
  rk_t mdl_rk;

  always @(negedge clk) begin
    if (res_n) begin
      if (hif.ct_valid && !ctv_prev && lat_pending) begin
        check("ct latency", 256'(cyc - t_acc), 256'(72));
        lat_pending = 1'b0;
      end
      if (hif.ct_valid && hif.ct_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL ct unexpected: got %h expected no output", hif.ct);
        end else begin
          check("ct", 256'(hif.ct), 256'(exp_q.pop_front()));
        end
      end
    end
    ctv_prev = hif.ct_valid;
  end

  initial forever begin
    @(posedge clk); #2;
    if (stall_rand) hif.ct_ready = 1'($urandom_range(0, 1));
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load_key(input logic [255:0] k);
    int n = 0;
    while (!hif.key_ready && n < 400) begin step(1); n++; end
    check("key_ready before load", 256'(hif.key_ready), 256'(1));
    hif.key_in = k; hif.key_load = 1'b1;
    step(1);
    hif.key_load = 1'b0;
    check("ks_key captured", ks_key, k);
    mdl_rk = expand(k);
  endtask

  task automatic wait_key(input bit exp_err, input string nm);
    int n = 0;
    while (!(hif.key_valid || hif.err) && n < 600) begin step(1); n++; end
    check({nm, " key_valid"}, 256'(hif.key_valid), 256'(!exp_err));
    check({nm, " err"}, 256'(hif.err), 256'(exp_err));
  endtask

  task automatic send_pt(input logic [127:0] p, input logic [127:0] e);
    int n = 0;
    hif.pt = p; hif.pt_valid = 1'b1;
    @(negedge clk);
    while (!hif.pt_ready && n < 400) begin @(negedge clk); n++; end
    check("pt accepted", 256'(hif.pt_ready), 256'(1));
    step(1);
    hif.pt_valid = 1'b0;
    t_acc = cyc; lat_pending = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin step(1); n++; end
    check("scoreboard drained", 256'(exp_q.size()), 256'(0));
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] k;
    for (int j = 0; j < 8; j++) k[j*32 +: 32] = $urandom();
    return k;
  endfunction

  initial begin
    int n;
    logic [127:0] p;
    hif.key_in = '0; hif.key_load = 1'b0; hif.pt = '0; hif.pt_valid = 1'b0;
    hif.ct_ready = 1'b1;

    // Reset state
    step(3);
    check("rst key_ready", 256'(hif.key_ready), 256'(1));
    check("rst key_valid", 256'(hif.key_valid), 256'(0));
    check("rst err", 256'(hif.err), 256'(0));
    check("rst ct_valid", 256'(hif.ct_valid), 256'(0));
    check("rst pt_ready", 256'(hif.pt_ready), 256'(0));
    check("rst ct", 256'(hif.ct), 256'(0));
    check("rst ks_key", ks_key, 256'(0));
    res_n = 1'b1;
    step(1);

    // Known-answer key load and encryption
    load_key(KAT_KEY);
    wait_key(1'b0, "kat");
    check("store[0]", 256'(dut.store[0]), 256'(64'h0706050403020100));
    check("store[3]", 256'(dut.store[3]), 256'(64'h1f1e1d1c1b1a1918));
    check("store[71]", 256'(dut.store[71]), 256'(mdl_rk[71]));
    send_pt(KAT_PT, KAT_CT);
    drain();

    // Backpressure: hold ct_ready low for 10 cycles
    hif.ct_ready = 1'b0;
    send_pt(KAT_PT, KAT_CT);
    n = 0;
    while (!hif.ct_valid && n < 200) begin step(1); n++; end
    for (int i = 0; i < 10; i++) begin
      check("hold ct_valid", 256'(hif.ct_valid), 256'(1));
      check("hold ct", 256'(hif.ct), 256'(KAT_CT));
      check("hold pt_ready", 256'(hif.pt_ready), 256'(0));
      step(1);
    end
    hif.ct_ready = 1'b1;
    step(1);
    check("release pt_ready", 256'(hif.pt_ready), 256'(1));
    check("release ct_valid", 256'(hif.ct_valid), 256'(0));

    // Randomised keys and blocks with random output stalls
    for (int r = 0; r < 3; r++) begin
      load_key(rand256());
      wait_key(1'b0, "rand");
      stall_rand = 1'b1;
      for (int b = 0; b < 3; b++) begin
        p = rand256()[127:0];
        send_pt(p, encrypt(mdl_rk, p));
        n = 0;
        while (!hif.pt_ready && n < 400) begin step(1); n++; end
      end
      drain();
      stall_rand = 1'b0; hif.ct_ready = 1'b1;
      step(1);
    end

    // Key-schedule timeout
    kg_hang = 1'b1;
    load_key(rand256());
    n = 0;
    while (!hif.err && n < 400) begin step(1); n++; end
    check("timeout window", 256'(n >= KS_TIMEOUT && n <= KS_TIMEOUT + 4), 256'(1));
    check("timeout err", 256'(hif.err), 256'(1));
    check("timeout pt_ready", 256'(hif.pt_ready), 256'(0));
    check("timeout key_valid", 256'(hif.key_valid), 256'(0));
    check("timeout key_ready", 256'(hif.key_ready), 256'(1));
    kg_hang = 1'b0;
    load_key(rand256());
    check("err cleared on rekey", 256'(hif.err), 256'(0));
    wait_key(1'b0, "recover");
    p = rand256()[127:0];
    send_pt(p, encrypt(mdl_rk, p));
    drain();

    // Wrong write counts: one short, one with an out-of-range index
    kg_nwrites = 71;
    load_key(rand256());
    wait_key(1'b1, "short");
    kg_nwrites = 73;
    load_key(rand256());
    wait_key(1'b1, "overrun");
    kg_nwrites = 72;

    // key_load and pt_valid together in READY: rekey wins
    load_key(KAT_KEY);
    wait_key(1'b0, "kat2");
    hif.key_in = rand256(); hif.key_load = 1'b1;
    hif.pt = KAT_PT; hif.pt_valid = 1'b1;
    #1;
    check("pt_ready masked by key_load", 256'(hif.pt_ready), 256'(0));
    mdl_rk = expand(hif.key_in);
    step(1);
    hif.key_load = 1'b0; hif.pt_valid = 1'b0;
    check("prio key_valid", 256'(hif.key_valid), 256'(0));
    check("prio key_ready", 256'(hif.key_ready), 256'(0));
    wait_key(1'b0, "prio");
    check("prio no ct", 256'(hif.ct_valid), 256'(0));

    // key_load during ENC is ignored
    p = rand256()[127:0];
    send_pt(p, encrypt(mdl_rk, p));
    step(5);
    hif.key_in = rand256(); hif.key_load = 1'b1;
    step(1);
    hif.key_load = 1'b0;
    check("enc key_ready", 256'(hif.key_ready), 256'(0));
    drain();
    check("enc key_valid kept", 256'(hif.key_valid), 256'(1));

    // Reset at round 40 aborts the block
    p = rand256()[127:0];
    send_pt(p, encrypt(mdl_rk, p));
    step(40);
    res_n = 1'b0;
    step(1);
    res_n = 1'b1;
    exp_q.delete(); lat_pending = 1'b0;
    check("midrst ct_valid", 256'(hif.ct_valid), 256'(0));
    check("midrst key_valid", 256'(hif.key_valid), 256'(0));
    check("midrst key_ready", 256'(hif.key_ready), 256'(1));
    check("midrst pt_ready", 256'(hif.pt_ready), 256'(0));
    step(100);
    check("midrst no late ct", 256'(hif.ct_valid), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
